csr_seq_master: RTL and testbench
=================================

# csr_seq_master

Command-driven initiator for the 4-entry control/status register bank. It accepts one register command at a time over a valid/ready handshake and drives the bank's addr/wr_en/data_in port, sampling its combinational read data. Supported commands are write, read and poll-until-match with timeout. It returns one response per command over a second valid/ready handshake. It sits between a host-side command source (sequencer, debug bridge) and the register bank.

## Interface
- DWIDTH, 32, register data width; matches the bank.
- TWIDTH, 16, poll timeout counter width.

- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at a rising edge.
- cmd_op  in  2  opcode: 0 write, 1 read, 2 poll, 3 read-modify-write.
- cmd_addr  in  2  register index.
- cmd_data  in  DWIDTH  write data, or poll/RMW compare value.
- cmd_mask  in  DWIDTH  bit mask for poll and RMW.
- cmd_timeout  in  TWIDTH  poll retry limit.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready at a rising edge.
- rsp_data  out  DWIDTH  result data.
- rsp_err  out  1  1 means poll timeout or unsupported opcode.
- csr_addr  out  2  to bank addr.
- csr_wr_en  out  1  to bank wr_en.
- csr_wdata  out  DWIDTH  to bank data_in.
- csr_rdata  in  DWIDTH  from bank data_out; combinational and valid in the same cycle as csr_addr.

## Operation
- FSM states: IDLE, WRITE, READ, POLL, RMW_RD, RMW_WR, RESP.
- **IDLE**
  - cmd_ready=1; all other handshake outputs are 0.
  - On accept, latch op, addr, data, mask and timeout; clear the retry counter.
  - Go to WRITE, READ, POLL or RMW_RD according to op.
- **WRITE**
  - One cycle with csr_wr_en=1, csr_addr=addr, csr_wdata=data.
  - Then go to RESP with rsp_data=data and rsp_err=0.
- **READ**
  - One cycle driving csr_addr=addr; capture csr_rdata at the end of the cycle.
  - Then go to RESP with rsp_err=0.
- **POLL**
  - Each cycle drive csr_addr and test (csr_rdata & mask) == (data & mask).
  - On match: go to RESP with rsp_data=csr_rdata and rsp_err=0.
  - On no match with counter == timeout: go to RESP with rsp_data=csr_rdata (last sample) and rsp_err=1.
  - Otherwise increment the counter and stay in POLL.
  - Maximum attempts = timeout+1; timeout=0 means a single attempt.
- **RMW_RD / RMW_WR**
  - RMW_RD reads as in READ and captures csr_rdata.
  - RMW_WR writes (rdata & ~mask) | (data & mask).
  - rsp_data is the written value; rsp_err=0.
- **RESP**
  - rsp_valid=1; rsp_data and rsp_err held stable.
  - cmd_ready=0.
  - On rsp_ready, go to IDLE.
- csr_wr_en is high only in WRITE and RMW_WR.
- csr_addr and csr_wdata are registered and hold their last values outside access states.
- Reset values: state IDLE; counter 0; csr_addr=0, csr_wdata=0, csr_wr_en=0; rsp_valid=0, rsp_data=0, rsp_err=0.
- cmd_ready is forced to 0 while reset is high.

## Timing
- Cycle numbering: command accepted at the end of cycle 0.
- Write and read: bank access in cycle 1; rsp_valid first high in cycle 2.
- Poll matching on attempt k (k ≥ 1): rsp_valid in cycle k+1. Timeout response arrives in cycle timeout+2.
- RMW: read in cycle 1, write in cycle 2, response in cycle 3.
- Minimum command period is 3 cycles: accept, access, and response with rsp_ready already high.
- The next cmd_ready goes high the cycle after the response handshake.
- Holding rsp_ready low stalls indefinitely, with no bank accesses in the meantime.
- Reset asserted mid-operation takes effect immediately:
  - csr_wr_en and rsp_valid drop asynchronously.
  - The in-flight command and its response are discarded; no partial RMW write occurs.
- Counter arithmetic is TWIDTH bits unsigned. The compare is made before increment, so the counter never wraps.

## Configuration
- CSR_SEQ_RMW_EN defined:
  - op 3 performs read-modify-write as above.
- CSR_SEQ_RMW_EN undefined:
  - RMW_RD and RMW_WR are not built.
  - op 3 goes straight from IDLE to RESP with rsp_data=0 and rsp_err=1.
  - No bank access occurs (csr_wr_en stays 0).

## Test plan
- Write then read back.
  - Write op, addr 2, data 0xDEADBEEF: csr_wr_en high exactly cycle 1 with addr 2; rsp in cycle 2 with data 0xDEADBEEF, err 0.
  - A following read of addr 2, with status2 looped from ctrl2, returns 0xDEADBEEF.
- Poll that matches.
  - Poll addr 1, mask 0x1, data 0x1, timeout 10; status1 bit0 rises at the 4th attempt.
  - Expect rsp in cycle 5, err 0, and exactly 4 cycles with csr_addr=1.
- Poll that times out.
  - Poll with timeout 3 and status never matching.
  - Expect 4 attempts, rsp in cycle 5, err 1, rsp_data equal to the last sampled status.
- Response backpressure.
  - Hold rsp_ready low for 6 cycles after rsp_valid.
  - Expect rsp_data and rsp_err stable, cmd_ready 0, csr_wr_en 0 throughout; IDLE the cycle after rsp_ready.
- Read-modify-write.
  - RMW on addr 0 with bank value 0xFFFF0000, mask 0x0000FF00, data 0x00001200.
  - With CSR_SEQ_RMW_EN defined: writes 0xFFFF1200 in cycle 2.
  - Without the macro: rsp err 1, data 0, no write.
- Reset mid-operation.
  - Assert reset during the POLL state.
  - Expect all outputs 0 immediately.
  - After release: cmd_ready 1, and a new write completes normally.

Source files
------------

// File: rtl/csr_seq_master.sv
// csr_seq_master: command-driven write/read/poll(/RMW) initiator for a 4-entry CSR bank.
// Read-modify-write (op 3) is built only when CSR_SEQ_RMW_EN is defined; otherwise op 3 is rejected with rsp_err.
module csr_seq_master #(
    parameter int DWIDTH = 32,
    parameter int TWIDTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [1:0]        cmd_addr,
    input  logic [DWIDTH-1:0] cmd_data,
    input  logic [DWIDTH-1:0] cmd_mask,
    input  logic [TWIDTH-1:0] cmd_timeout,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DWIDTH-1:0] rsp_data,
    output logic              rsp_err,
    output logic [1:0]        csr_addr,
    output logic              csr_wr_en,
    output logic [DWIDTH-1:0] csr_wdata,
    input  logic [DWIDTH-1:0] csr_rdata
);
    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        POLL,
`ifdef CSR_SEQ_RMW_EN
        RMW_RD,
        RMW_WR,
`endif
        RESP
    } state_t;

`ifdef CSR_SEQ_RMW_EN
    localparam state_t OP3_STATE = RMW_RD;
    localparam bit     RMW_EN    = 1'b1;
`else
    localparam state_t OP3_STATE = RESP;
    localparam bit     RMW_EN    = 1'b0;
`endif

    state_t            state, next;
    logic [DWIDTH-1:0] data, mask;
    logic [TWIDTH-1:0] timeout, cnt;
    logic              accept, hit;

    assign accept    = cmd_valid & cmd_ready;
    assign hit       = ((csr_rdata ^ data) & mask) == '0;
    // Handshake strobes decode the async-reset state so they drop with reset.
    assign cmd_ready = (state == IDLE) & ~reset;
    assign rsp_valid = state == RESP;
`ifdef CSR_SEQ_RMW_EN
    assign csr_wr_en = (state == WRITE) | (state == RMW_WR);
`else
    assign csr_wr_en = state == WRITE;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:        if (accept) next = (cmd_op == 2'd0) ? WRITE :
                                            (cmd_op == 2'd1) ? READ  :
                                            (cmd_op == 2'd2) ? POLL  : OP3_STATE;
            WRITE, READ: next = RESP;
            POLL:        next = (hit || cnt == timeout) ? RESP : POLL;
`ifdef CSR_SEQ_RMW_EN
            RMW_RD:      next = RMW_WR;
            RMW_WR:      next = RESP;
`endif
            RESP:        if (rsp_ready) next = IDLE;
            default:     next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data      <= '0;
            mask      <= '0;
            timeout   <= '0;
            cnt       <= '0;
            csr_addr  <= '0;
            csr_wdata <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    data     <= cmd_data;
                    mask     <= cmd_mask;
                    timeout  <= cmd_timeout;
                    cnt      <= '0;
                    rsp_data <= '0;
                    rsp_err  <= (cmd_op == 2'd3) & ~RMW_EN;
                    // A rejected op 3 never touches the bank, so the bus keeps its last values.
                    if (cmd_op != 2'd3 || RMW_EN) csr_addr <= cmd_addr;
                    if (cmd_op == 2'd0) csr_wdata <= cmd_data;
                end
                WRITE: begin
                    rsp_data <= data;
                    rsp_err  <= 1'b0;
                end
                READ: begin
                    rsp_data <= csr_rdata;
                    rsp_err  <= 1'b0;
                end
                POLL: begin
                    rsp_data <= csr_rdata;
                    rsp_err  <= ~hit & (cnt == timeout);
                    if (!hit && cnt != timeout) cnt <= cnt + 1'b1;
                end
`ifdef CSR_SEQ_RMW_EN
                RMW_RD: csr_wdata <= (csr_rdata & ~mask) | (data & mask);
                RMW_WR: begin
                    rsp_data <= csr_wdata;
                    rsp_err  <= 1'b0;
                end
`endif
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_csr_seq_master.sv
// tb_csr_seq_master: randomized and directed check of csr_seq_master against a command-level model.
module tb_csr_seq_master;
    localparam int DW = 32;
    localparam int TW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0, cmd_ready;
    logic [1:0]    cmd_op = '0, cmd_addr = '0;
    logic [DW-1:0] cmd_data = '0, cmd_mask = '0;
    logic [TW-1:0] cmd_timeout = '0;
    logic          rsp_valid, rsp_ready = 1'b0, rsp_err;
    logic [DW-1:0] rsp_data;
    logic [1:0]    csr_addr;
    logic          csr_wr_en;
    logic [DW-1:0] csr_wdata, csr_rdata;

    always #5 clk = ~clk;

    csr_seq_master #(.DWIDTH(DW), .TWIDTH(TW)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
        .cmd_data(cmd_data), .cmd_mask(cmd_mask), .cmd_timeout(cmd_timeout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .csr_addr(csr_addr), .csr_wr_en(csr_wr_en), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata)
    );

    // Bank device plus an optional status source whose value flips at a chosen cycle after accept.
    logic [DW-1:0] bank [4];
    logic [DW-1:0] mbank [4];
    int            cyc = 0, acc_cyc = 0;
    bit            stat_on = 1'b0;
    logic [1:0]    stat_addr = '0;
    logic [DW-1:0] stat_lo = '0, stat_hi = '0;
    int            stat_rise = 1;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (csr_wr_en) bank[csr_addr] <= csr_wdata;
    assign csr_rdata = (stat_on && csr_addr == stat_addr) ?
                       ((cyc - acc_cyc >= stat_rise) ? stat_hi : stat_lo) : bank[csr_addr];

    int n_cmp = 0, n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Command-level reference: what each command must return and when, from the op rules.
    task automatic model(input logic [1:0] op, input logic [1:0] a, input logic [DW-1:0] d,
                         input logic [DW-1:0] m, input int tmo, output logic [DW-1:0] ed,
                         output logic ee, output int lat, output int wr, output int att);
        logic [DW-1:0] v;
        bit done;
        ed = '0; ee = 1'b0; lat = 2; wr = 0; att = 0;
        case (op)
            2'd0: begin mbank[a] = d; ed = d; wr = 1; end
            2'd1: ed = mbank[a];
            2'd2: begin
                done = 1'b0;
                for (int k = 1; k <= tmo + 1 && !done; k++) begin
                    v = (stat_on && a == stat_addr) ? ((k >= stat_rise) ? stat_hi : stat_lo) : mbank[a];
                    if ((v & m) == (d & m) || k == tmo + 1) begin
                        done = 1'b1; ed = v; ee = (v & m) != (d & m); lat = k + 1; att = k;
                    end
                end
            end
            default: begin
`ifdef CSR_SEQ_RMW_EN
                mbank[a] = (mbank[a] & ~m) | (d & m);
                ed = mbank[a]; lat = 3; wr = 1;
`else
                ee = 1'b1; lat = 1;
`endif
            end
        endcase
    endtask

    task automatic start_cmd(input logic [1:0] op, input logic [1:0] a, input logic [DW-1:0] d,
                             input logic [DW-1:0] m, input int tmo, output bit ok);
        @(posedge clk) #1;
        cmd_op = op; cmd_addr = a; cmd_data = d; cmd_mask = m; cmd_timeout = TW'(tmo);
        cmd_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (cmd_ready) ok = 1'b1;
            else @(posedge clk) #1;
        end
        acc_cyc = cyc;
        if (!ok) chk("accept", 0, 1);
        @(posedge clk) #1 cmd_valid = 1'b0;
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic [1:0] a, input logic [DW-1:0] d,
                          input logic [DW-1:0] m, input int tmo, input int stall);
        logic [DW-1:0] ed;
        logic          ee;
        int            elat, ewr, eatt, lat, wr, wr_k, att;
        bit            ok;
        model(op, a, d, m, tmo, ed, ee, elat, ewr, eatt);
        start_cmd(op, a, d, m, tmo, ok);
        if (!ok) return;
        lat = -1; wr = 0; wr_k = 0; att = 0;
        for (int k = 1; k <= 60 && lat < 0; k++) begin
            @(negedge clk);
            if (rsp_valid) lat = k;
            else begin
                if (csr_wr_en) begin wr++; wr_k = k; chk("wr_addr", csr_addr, a); end
                if (csr_addr == a) att++;
            end
        end
        chk("latency", lat, elat);
        if (lat < 0) return;
        chk("wr_count", wr, ewr);
        if (ewr > 0) chk("wr_cycle", wr_k, lat - 1);
        if (op == 2'd2) chk("poll_attempts", att, eatt);
        chk("rsp_data", rsp_data, ed);
        chk("rsp_err", rsp_err, ee);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("stall_hold", {rsp_valid, cmd_ready, csr_wr_en, rsp_err, rsp_data}, {3'b100, ee, ed});
        end
        rsp_ready = 1'b1;
        @(posedge clk) #1 rsp_ready = 1'b0;
        @(negedge clk);
        chk("idle_after_rsp", {cmd_ready, rsp_valid}, 2'b10);
    endtask

    task automatic chk_zero_outs(input string tag);
        chk(tag, {cmd_ready, rsp_valid, csr_wr_en, rsp_err, csr_addr}, '0);
        chk({tag, "_wdata"}, csr_wdata, '0);
        chk({tag, "_rdata"}, rsp_data, '0);
    endtask

    initial begin
        logic [DW-1:0] d, m, keep;
        logic [1:0]    a, op;
        int            tmo;
        bit            ok;
        for (int i = 0; i < 4; i++) begin
            bank[i] = $urandom;
            mbank[i] = bank[i];
        end
        @(negedge clk);
        chk_zero_outs("reset_state");
        @(posedge clk) #1 reset = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", cmd_ready, 1'b1);

        do_cmd(2'd0, 2'd2, 32'hDEADBEEF, '0, 0, 0);
        do_cmd(2'd1, 2'd2, '0, '0, 0, 0);

        stat_on = 1'b1; stat_addr = 2'd1; stat_lo = 32'h0000_00A4; stat_hi = 32'h0000_00A5; stat_rise = 4;
        do_cmd(2'd2, 2'd1, 32'h1, 32'h1, 10, 0);
        stat_rise = 1000;
        do_cmd(2'd2, 2'd1, 32'h1, 32'h1, 3, 0);
        do_cmd(2'd2, 2'd1, 32'h1, 32'h1, 0, 0);
        stat_rise = 1;
        do_cmd(2'd2, 2'd1, 32'h1, 32'h1, 0, 0);
        stat_on = 1'b0;

        do_cmd(2'd0, 2'd3, 32'h1234_5678, '0, 0, 6);

        bank[0] = 32'hFFFF0000; mbank[0] = 32'hFFFF0000;
        do_cmd(2'd3, 2'd0, 32'h0000_1200, 32'h0000_FF00, 0, 0);
        do_cmd(2'd1, 2'd0, '0, '0, 0, 1);

        for (int n = 0; n < 60; n++) begin
            op = 2'($urandom_range(0, 3));
            a = 2'($urandom_range(0, 3));
            d = $urandom; m = $urandom; tmo = $urandom_range(0, 7);
            if (op == 2'd2) begin
                stat_on = 1'b1; stat_addr = a; stat_lo = $urandom; stat_hi = $urandom;
                stat_rise = $urandom_range(1, 9); d = stat_hi;
            end
            do_cmd(op, a, d, m, tmo, $urandom_range(0, 3));
            stat_on = 1'b0;
        end

        stat_on = 1'b1; stat_addr = 2'd1; stat_lo = 32'h0; stat_rise = 1000;
        start_cmd(2'd2, 2'd1, 32'h1, 32'h1, 20, ok);
        repeat (3) @(negedge clk);
        chk("poll_busy", {cmd_ready, rsp_valid, csr_addr}, 4'b0001);
        #2 reset = 1'b1;
        #1 chk_zero_outs("reset_mid_poll");
        @(posedge clk) #1 reset = 1'b0;
        stat_on = 1'b0;
        @(negedge clk);
        chk("ready_after_mid_reset", cmd_ready, 1'b1);
        do_cmd(2'd0, 2'd1, 32'hCAFE_F00D, '0, 0, 0);

        keep = mbank[2];
        start_cmd(2'd3, 2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, ok);
        @(negedge clk) reset = 1'b1;
        #1 chk("reset_mid_rmw_wr_en", csr_wr_en, 1'b0);
        @(posedge clk);
        @(posedge clk) #1 reset = 1'b0;
        @(negedge clk);
        chk("rmw_aborted", bank[2], keep);
        do_cmd(2'd1, 2'd2, '0, '0, 0, 0);

        for (int i = 0; i < 4; i++) chk("bank_final", bank[i], mbank[i]);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
